b16_stack_cache: RTL

//  Parametrised successor of the b16 data/return stack: 2**DEP-entry register stack with

---
 rtl/b16_stack_cache.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/b16_stack_cache.sv
// b16_stack_cache: 2**DEP-entry register stack that spills its bottom entry to memory and fills it back.
// Latency: push/pop/replace take effect on the next clk edge; out is combinational; memory request 1 cycle after the decision.
// Backpressure: stall is raised while a push/pop cannot be accepted (no room, or an entry is in flight); the core holds its request.
module b16_stack_cache #(
  parameter int L    = 16,
  parameter int DEP  = 2,
  parameter int HI   = 3,
  parameter int LO   = 1,
  parameter int MMAX = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [L-1:0]               in,
  output logic [L-1:0]               out,
  output logic                       stall,
  output logic [DEP:0]               cnt,
  output logic [$clog2(MMAX+1)-1:0]  mdepth,
  output logic                       ovf,
  output logic                       unf,
  input  logic                       clr_flags,
  input  logic [L-1:0]               mbase,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [L-1:0]               mem_addr,
  output logic [L-1:0]               mem_wdata,
  input  logic [L-1:0]               mem_rdata,
  input  logic                       mem_ack
);

  localparam int CAP = 2 ** DEP;
  localparam int MW  = $clog2(MMAX + 1);

  localparam logic [DEP:0]  CAP_C   = (DEP+1)'(CAP);
  localparam logic [DEP:0]  CAPM1_C = (DEP+1)'(CAP - 1);
  localparam logic [DEP:0]  HI_C    = (DEP+1)'(HI);
  localparam logic [DEP:0]  LO_C    = (DEP+1)'(LO);
  localparam logic [DEP:0]  ONE_C   = (DEP+1)'(1);
  localparam logic [MW-1:0] MMAX_C  = MW'(MMAX);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t          state;
  logic [L-1:0]    stack [CAP];
  logic [DEP-1:0]  top, bot;
  logic [DEP-1:0]  top_m1, bot_m1;
  logic [MW-1:0]   md_m1;

  logic full, cnt_zero, mem_full, mem_empty;
  logic in_spill, in_fill, spill_ack, fill_ack;
  logic push_only, pop_only, both;
  logic drop, under_pop, under_both;
  logic push_stall, pop_stall, both_stall;
  logic do_push, do_pop, do_repl;
  logic ovf_evt, unf_evt;

  assign top_m1    = top - DEP'(1);
  assign bot_m1    = bot - DEP'(1);
  assign md_m1     = mdepth - MW'(1);

  assign full      = (cnt == CAP_C);
  assign cnt_zero  = (cnt == '0);
  assign mem_full  = (mdepth == MMAX_C);
  assign mem_empty = (mdepth == '0);

  assign in_spill  = (state == SPILL);
  assign in_fill   = (state == FILL);
  // mem_req is high exactly in SPILL/FILL, so a stray ack while idle is ignored here
  assign spill_ack = in_spill & mem_ack;
  assign fill_ack  = in_fill & mem_ack;

  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign both      = push & pop;

  // Everything full (chip and memory) with nothing in flight: the push is lost, not held
  assign drop       = push_only & full & mem_full & (state == IDLE);
  // A fill landing at cnt==CAP-1 together with a push would overflow the register file
  assign push_stall = push_only & ~drop & (full | ((cnt == CAPM1_C) & in_fill));
  // Nothing to pop yet (fill pending), or the last on-chip entry is being spilled
  assign pop_stall  = pop_only & ((cnt_zero & ~mem_empty) | ((cnt == ONE_C) & in_spill));
  // Replacing the top needs an on-chip top that is not the entry in flight
  assign both_stall = both & ((cnt_zero & ~mem_empty) | ((cnt == ONE_C) & in_spill));
  assign under_pop  = pop_only & cnt_zero & mem_empty;
  // Replace on a totally empty stack: the pop half underflows, the push half lands
  assign under_both = both & cnt_zero & mem_empty;

  assign stall   = push_stall | pop_stall | both_stall;
  assign do_push = (push_only & ~push_stall & ~drop) | under_both;
  assign do_pop  = pop_only & ~pop_stall & ~under_pop;
  assign do_repl = both & ~both_stall & ~cnt_zero;
  assign ovf_evt = drop;
  assign unf_evt = under_pop | under_both;

  // Top of stack is only meaningful while something is on chip
  assign out = cnt_zero ? '0 : stack[top_m1];

  // Register file writes: push at top, replace at top-1, fill below the bottom
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CAP; i++) stack[i] <= '0;
    end else begin
      if (do_push)  stack[top]    <= in;
      if (do_repl)  stack[top_m1] <= in;
      if (fill_ack) stack[bot_m1] <= mem_rdata;
    end
  end

  // Occupancy counters and circular pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      mdepth <= '0;
      top    <= '0;
      bot    <= '0;
    end else begin
      cnt    <= cnt + (DEP+1)'(do_push) - (DEP+1)'(do_pop)
                    + (DEP+1)'(fill_ack) - (DEP+1)'(spill_ack);
      mdepth <= mdepth + MW'(spill_ack) - MW'(fill_ack);
      top    <= top + DEP'(do_push) - DEP'(do_pop);
      bot    <= bot + DEP'(spill_ack) - DEP'(fill_ack);
    end
  end

  // Sticky error flags; a new event beats a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_evt)        ovf <= 1'b1;
      else if (clr_flags) ovf <= 1'b0;
      if (unf_evt)        unf <= 1'b1;
      else if (clr_flags) unf <= 1'b0;
    end
  end

  // Spill/fill sequencer: one memory access per IDLE visit, request fields frozen until ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cnt >= HI_C && mdepth < MMAX_C) begin
            state     <= SPILL;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= mbase + L'({mdepth, 1'b0});
            mem_wdata <= stack[bot];
          end else if (cnt <= LO_C && !mem_empty) begin
            state     <= FILL;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= mbase + L'({md_m1, 1'b0});
          end
        end
        SPILL, FILL: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
